// File: rtl/m_unit_if.sv
// M-unit request/response bundle between the execute stage and the multiply/divide unit.
// Latency: none, this is wiring only.
// Backpressure: none here; the unit stalls execute through m_unit_busy.
interface m_unit_if #(
  parameter int XLEN = 32
);
  logic            m_unit_start;
  logic            m_unit_kill;
  logic [2:0]      func3;
  logic [XLEN-1:0] op1;
  logic [XLEN-1:0] op2;
  logic [4:0]      rd;
  logic            m_unit_busy;
  logic            m_unit_ready;
  logic [XLEN-1:0] m_unit_result;
  logic            m_unit_wr;
  logic [4:0]      m_unit_dest;

  // Execute side drives the request and observes the result.
  modport master (
    output m_unit_start, m_unit_kill, func3, op1, op2, rd,
    input  m_unit_busy, m_unit_ready, m_unit_result, m_unit_wr, m_unit_dest
  );

  // The multiply/divide unit consumes the request and drives the result.
  modport slave (
    input  m_unit_start, m_unit_kill, func3, op1, op2, rd,
    output m_unit_busy, m_unit_ready, m_unit_result, m_unit_wr, m_unit_dest
  );
endinterface

// File: rtl/m_unit.sv
// Iterative RV32M multiply/divide unit; optional single-cycle multiplier under M_UNIT_FAST_MUL_EN.
// Latency: 33 cycles accept-to-ready iterative, 1 for divide special cases, 2 for fast multiply.
// Backpressure: m_unit_busy stalls IF/ID/EX; starts while BUSY are ignored, kill aborts.
module m_unit #(
  parameter int XLEN = 32
) (
  input logic     clk,
  input logic     rst_n,
  m_unit_if.slave m_if
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t              r_state;
  logic [4:0]          r_cnt;
  logic [2:0]          r_func3;
  logic [4:0]          r_rd;
  logic                r_neg;    // operand signs differ
  logic                r_sgn1;   // dividend sign, used for the remainder
  logic [2*XLEN-1:0]   r_acc;    // remainder:quotient or product:multiplier
  logic [XLEN-1:0]     r_den;    // divisor or multiplicand magnitude
  logic                r_ready;
  logic [XLEN-1:0]     r_result;
  logic                r_wr;
  logic [4:0]          r_dest;

  logic                w_sgn_op1, w_sgn_op2, w_s1, w_s2;
  logic [XLEN-1:0]     w_mag1, w_mag2;
  logic                w_div0, w_ovf, w_special, w_accept;
  logic [XLEN-1:0]     w_spec_res;
  logic [XLEN:0]       w_rem_sh;
  logic                w_ge;
  logic [XLEN-1:0]     w_sub;
  logic [XLEN:0]       w_sum;
  logic [2*XLEN-1:0]   w_div_nacc, w_mul_nacc, w_nacc, w_prod;
  logic [XLEN-1:0]     w_q, w_r, w_fin;

  // Operand decode for the op being offered this cycle.
  assign w_sgn_op1 = (m_if.func3 == 3'b001) || (m_if.func3 == 3'b010) ||
                     (m_if.func3 == 3'b100) || (m_if.func3 == 3'b110);
  assign w_sgn_op2 = (m_if.func3 == 3'b001) || (m_if.func3 == 3'b100) ||
                     (m_if.func3 == 3'b110);
  assign w_s1      = w_sgn_op1 & m_if.op1[XLEN-1];
  assign w_s2      = w_sgn_op2 & m_if.op2[XLEN-1];
  assign w_mag1    = w_s1 ? -m_if.op1 : m_if.op1;
  assign w_mag2    = w_s2 ? -m_if.op2 : m_if.op2;

  // Divide special cases resolve without iterating.
  assign w_div0     = m_if.func3[2] && (m_if.op2 == '0);
  assign w_ovf      = m_if.func3[2] && !m_if.func3[0] &&
                      (m_if.op1 == 32'h8000_0000) && (m_if.op2 == 32'hFFFF_FFFF);
  assign w_special  = w_div0 || w_ovf;
  assign w_spec_res = w_div0 ? (m_if.func3[1] ? m_if.op1 : '1)
                             : (m_if.func3[1] ? '0 : 32'h8000_0000);

  assign w_accept = m_if.m_unit_start && !m_if.m_unit_kill && (r_state != S_BUSY);

  // Restoring divide step: shift left, subtract divisor if it fits.
  assign w_rem_sh   = r_acc[2*XLEN-1:XLEN-1];
  assign w_ge       = (w_rem_sh >= {1'b0, r_den});
  assign w_sub      = w_rem_sh[XLEN-1:0] - r_den;
  assign w_div_nacc = w_ge ? {w_sub, r_acc[XLEN-2:0], 1'b1}
                           : {w_rem_sh[XLEN-1:0], r_acc[XLEN-2:0], 1'b0};

  // Shift-add multiply step: add multiplicand on LSB, shift right.
  assign w_sum      = {1'b0, r_acc[2*XLEN-1:XLEN]} + {1'b0, r_den};
  assign w_mul_nacc = r_acc[0] ? {w_sum, r_acc[XLEN-1:1]}
                               : {1'b0, r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1:1]};
  assign w_nacc     = r_func3[2] ? w_div_nacc : w_mul_nacc;

  // Sign fix-up applied to the final iteration's value.
  assign w_q    = w_nacc[XLEN-1:0];
  assign w_r    = w_nacc[2*XLEN-1:XLEN];
  assign w_prod = r_neg ? -w_nacc : w_nacc;
  assign w_fin  = r_func3[2] ? (r_func3[1] ? (r_sgn1 ? -w_r : w_r) : (r_neg ? -w_q : w_q))
                             : ((r_func3[1:0] == 2'b00) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN]);

`ifdef M_UNIT_FAST_MUL_EN
  logic signed [XLEN:0]     r_fa, r_fb;
  logic signed [2*XLEN-1:0] w_fa, w_fb, w_fprod;
  logic [XLEN-1:0]          w_fres;
  // 33-bit sign extension makes one signed multiply cover all four multiply forms.
  assign w_fa    = {{(XLEN-1){r_fa[XLEN]}}, r_fa};
  assign w_fb    = {{(XLEN-1){r_fb[XLEN]}}, r_fb};
  assign w_fprod = w_fa * w_fb;
  assign w_fres  = (r_func3[1:0] == 2'b00) ? w_fprod[XLEN-1:0] : w_fprod[2*XLEN-1:XLEN];

  // Capture sign-extended raw operands on accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fa <= '0;
      r_fb <= '0;
    end else if (w_accept) begin
      r_fa <= {w_sgn_op1 & m_if.op1[XLEN-1], m_if.op1};
      r_fb <= {w_sgn_op2 & m_if.op2[XLEN-1], m_if.op2};
    end
  end
`endif

  // Stall covers the accept cycle of any op that will iterate.
  assign m_if.m_unit_busy   = (r_state == S_BUSY) || (w_accept && !w_special);
  // A kill landing in the DONE cycle suppresses the pulse already registered.
  assign m_if.m_unit_ready  = r_ready && !m_if.m_unit_kill;
  assign m_if.m_unit_wr     = r_wr && !m_if.m_unit_kill;
  assign m_if.m_unit_result = m_if.m_unit_kill ? '0 : r_result;
  assign m_if.m_unit_dest   = m_if.m_unit_kill ? '0 : r_dest;

  // Control FSM, datapath iteration and registered result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_func3  <= '0;
      r_rd     <= '0;
      r_neg    <= 1'b0;
      r_sgn1   <= 1'b0;
      r_acc    <= '0;
      r_den    <= '0;
      r_ready  <= 1'b0;
      r_result <= '0;
      r_wr     <= 1'b0;
      r_dest   <= '0;
    end else begin
      r_ready  <= 1'b0;
      r_result <= '0;
      r_wr     <= 1'b0;
      r_dest   <= '0;
      if (m_if.m_unit_kill) begin
        r_state <= S_IDLE;
      end else if (w_accept) begin
        r_func3 <= m_if.func3;
        r_rd    <= m_if.rd;
        r_neg   <= w_s1 ^ w_s2;
        r_sgn1  <= w_s1;
        r_cnt   <= '0;
        r_acc   <= {{XLEN{1'b0}}, w_mag1};
        r_den   <= w_mag2;
        if (w_special) begin
          r_state  <= S_DONE;
          r_ready  <= 1'b1;
          r_result <= w_spec_res;
          r_wr     <= (m_if.rd != 5'd0);
          r_dest   <= m_if.rd;
        end else begin
          r_state <= S_BUSY;
        end
      end else if (r_state == S_BUSY) begin
`ifdef M_UNIT_FAST_MUL_EN
        if (!r_func3[2]) begin
          r_state  <= S_DONE;
          r_ready  <= 1'b1;
          r_result <= w_fres;
          r_wr     <= (r_rd != 5'd0);
          r_dest   <= r_rd;
        end else
`endif
        begin
          r_acc <= w_nacc;
          r_cnt <= r_cnt + 5'd1;
          if (r_cnt == 5'd31) begin
            r_state  <= S_DONE;
            r_ready  <= 1'b1;
            r_result <= w_fin;
            r_wr     <= (r_rd != 5'd0);
            r_dest   <= r_rd;
          end
        end
      end else begin
        r_state <= S_IDLE;
      end
    end
  end

endmodule

// File: tb/tb_m_unit.sv
// Directed bench for m_unit: reset, multiply, divide, special cases, kill, reset mid-op, back-to-back.
// Latency: expected accept-to-ready counts are hand-derived per op class.
// Backpressure: busy is sampled at the accept cycle and counted while waiting for ready.
module tb_m_unit;

  logic clk;
  logic rst_n;
  int   n_cmp = 0;
  int   n_bad = 0;

`ifdef M_UNIT_FAST_MUL_EN
  localparam int LAT_MUL = 2;
`else
  localparam int LAT_MUL = 33;
`endif
  localparam int LAT_DIV = 33;

  m_unit_if u_if ();
  m_unit u_dut (.clk(clk), .rst_n(rst_n), .m_if(u_if));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one op (at the next negedge unless now=1) and wait for its ready pulse.
  task automatic exec(input bit now, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] d, output int lat, output logic [31:0] res,
                      output logic wr, output logic [4:0] dst, output logic bsy0, output int bcnt);
    if (!now) @(negedge clk);
    u_if.m_unit_start = 1'b1;
    u_if.func3 = f3;
    u_if.op1   = a;
    u_if.op2   = b;
    u_if.rd    = d;
    #1 bsy0 = u_if.m_unit_busy;
    @(posedge clk);
    #1;
    u_if.m_unit_start = 1'b0;
    u_if.op1   = $urandom;
    u_if.op2   = $urandom;
    u_if.rd    = 5'($urandom);
    u_if.func3 = 3'($urandom);
    bcnt = 0;
    for (lat = 1; lat <= 100; lat++) begin
      @(negedge clk);
      if (u_if.m_unit_ready) break;
      if (u_if.m_unit_busy) bcnt++;
    end
    res = u_if.m_unit_result;
    wr  = u_if.m_unit_wr;
    dst = u_if.m_unit_dest;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    u_if.m_unit_start = 1'b0;
    u_if.m_unit_kill  = 1'b0;
    u_if.func3 = '0;
    u_if.op1   = '0;
    u_if.op2   = '0;
    u_if.rd    = '0;
    #12;
    n_cmp++; if (u_if.m_unit_busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", u_if.m_unit_busy); end
    n_cmp++; if (u_if.m_unit_ready !== 1'b0) begin n_bad++; $display("FAIL reset_ready got %b want 0", u_if.m_unit_ready); end
    n_cmp++; if (u_if.m_unit_result !== 32'h0) begin n_bad++; $display("FAIL reset_result got %h want 0", u_if.m_unit_result); end
    n_cmp++; if (u_if.m_unit_wr !== 1'b0) begin n_bad++; $display("FAIL reset_wr got %b want 0", u_if.m_unit_wr); end
    n_cmp++; if (u_if.m_unit_dest !== 5'd0) begin n_bad++; $display("FAIL reset_dest got %0d want 0", u_if.m_unit_dest); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_mul();
    int lat, bcnt; logic [31:0] res; logic wr, bsy0; logic [4:0] dst;
    exec(1'b0, 3'b000, 32'd7, 32'hFFFF_FFFD, 5'd5, lat, res, wr, dst, bsy0, bcnt);
    n_cmp++; if (res !== 32'hFFFF_FFEB) begin n_bad++; $display("FAIL mul_result got %h want ffffffeb", res); end
    n_cmp++; if (lat != LAT_MUL) begin n_bad++; $display("FAIL mul_latency got %0d want %0d", lat, LAT_MUL); end
    n_cmp++; if (wr !== 1'b1) begin n_bad++; $display("FAIL mul_wr got %b want 1", wr); end
    n_cmp++; if (dst !== 5'd5) begin n_bad++; $display("FAIL mul_dest got %0d want 5", dst); end
    n_cmp++; if (bsy0 !== 1'b1) begin n_bad++; $display("FAIL mul_busy_accept got %b want 1", bsy0); end
    n_cmp++; if (bcnt != LAT_MUL - 1) begin n_bad++; $display("FAIL mul_busy_cycles got %0d want %0d", bcnt, LAT_MUL - 1); end
    @(negedge clk);
    n_cmp++; if (u_if.m_unit_ready !== 1'b0) begin n_bad++; $display("FAIL mul_pulse got %b want 0", u_if.m_unit_ready); end
    n_cmp++; if (u_if.m_unit_result !== 32'h0) begin n_bad++; $display("FAIL mul_result_idle got %h want 0", u_if.m_unit_result); end
  endtask

  task automatic test_mulh();
    int lat, bcnt; logic [31:0] res; logic wr, bsy0; logic [4:0] dst;
    exec(1'b0, 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, lat, res, wr, dst, bsy0, bcnt);
    n_cmp++; if (res !== 32'hFFFF_FFFE) begin n_bad++; $display("FAIL mulhu_result got %h want fffffffe", res); end
    n_cmp++; if (lat != LAT_MUL) begin n_bad++; $display("FAIL mulhu_latency got %0d want %0d", lat, LAT_MUL); end
    exec(1'b0, 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, lat, res, wr, dst, bsy0, bcnt);
    n_cmp++; if (res !== 32'h0000_0000) begin n_bad++; $display("FAIL mulh_result got %h want 00000000", res); end
    exec(1'b0, 3'b010, 32'hFFFF_FFFF, 32'd2, 5'd8, lat, res, wr, dst, bsy0, bcnt);
    n_cmp++; if (res !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL mulhsu_result got %h want ffffffff", res); end
    n_cmp++; if (dst !== 5'd8) begin n_bad++; $display("FAIL mulhsu_dest got %0d want 8", dst); end
  endtask

  task automatic test_div();
    int lat, bcnt; logic [31:0] res; logic wr, bsy0; logic [4:0] dst;
    exec(1'b0, 3'b100, 32'hFFFF_FFEC, 32'd3, 5'd10, lat, res, wr, dst, bsy0, bcnt);
    n_cmp++; if (res !== 32'hFFFF_FFFA) begin n_bad++; $display("FAIL div_result got %h want fffffffa", res); end
    n_cmp++; if (lat != LAT_DIV) begin n_bad++; $display("FAIL div_latency got %0d want %0d", lat, LAT_DIV); end
    exec(1'b0, 3'b110, 32'hFFFF_FFEC, 32'd3, 5'd11, lat, res, wr, dst, bsy0, bcnt);
    n_cmp++; if (res !== 32'hFFFF_FFFE) begin n_bad++; $display("FAIL rem_result got %h want fffffffe", res); end
    exec(1'b0, 3'b101, 32'd100, 32'd7, 5'd12, lat, res, wr, dst, bsy0, bcnt);
    n_cmp++; if (res !== 32'd14) begin n_bad++; $display("FAIL divu_result got %h want 0000000e", res); end
    n_cmp++; if (lat != LAT_DIV) begin n_bad++; $display("FAIL divu_latency got %0d want %0d", lat, LAT_DIV); end
    exec(1'b0, 3'b111, 32'd100, 32'd7, 5'd13, lat, res, wr, dst, bsy0, bcnt);
    n_cmp++; if (res !== 32'd2) begin n_bad++; $display("FAIL remu_result got %h want 00000002", res); end
    exec(1'b0, 3'b100, 32'd7, 32'hFFFF_FFFE, 5'd14, lat, res, wr, dst, bsy0, bcnt);
    n_cmp++; if (res !== 32'hFFFF_FFFD) begin n_bad++; $display("FAIL div_negdivisor got %h want fffffffd", res); end
    exec(1'b0, 3'b110, 32'd7, 32'hFFFF_FFFE, 5'd15, lat, res, wr, dst, bsy0, bcnt);
    n_cmp++; if (res !== 32'd1) begin n_bad++; $display("FAIL rem_negdivisor got %h want 00000001", res); end
  endtask

  task automatic test_special();
    int lat, bcnt; logic [31:0] res; logic wr, bsy0; logic [4:0] dst;
    exec(1'b0, 3'b101, 32'd123, 32'd0, 5'd3, lat, res, wr, dst, bsy0, bcnt);
    n_cmp++; if (res !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL divu0_result got %h want ffffffff", res); end
    n_cmp++; if (lat != 1) begin n_bad++; $display("FAIL divu0_latency got %0d want 1", lat); end
    n_cmp++; if (bsy0 !== 1'b0) begin n_bad++; $display("FAIL divu0_busy got %b want 0", bsy0); end
    exec(1'b0, 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd4, lat, res, wr, dst, bsy0, bcnt);
    n_cmp++; if (res !== 32'h0) begin n_bad++; $display("FAIL removf_result got %h want 00000000", res); end
    n_cmp++; if (lat != 1) begin n_bad++; $display("FAIL removf_latency got %0d want 1", lat); end
    exec(1'b0, 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd4, lat, res, wr, dst, bsy0, bcnt);
    n_cmp++; if (res !== 32'h8000_0000) begin n_bad++; $display("FAIL divovf_result got %h want 80000000", res); end
    exec(1'b0, 3'b111, 32'd55, 32'd0, 5'd0, lat, res, wr, dst, bsy0, bcnt);
    n_cmp++; if (res !== 32'd55) begin n_bad++; $display("FAIL remu0_result got %h want 00000037", res); end
    n_cmp++; if (wr !== 1'b0) begin n_bad++; $display("FAIL rd0_wr got %b want 0", wr); end
    n_cmp++; if (lat != 1) begin n_bad++; $display("FAIL rd0_ready got latency %0d want 1", lat); end
  endtask

  task automatic test_kill();
    int seen;
    @(negedge clk);
    u_if.m_unit_start = 1'b1;
    u_if.func3 = 3'b100;
    u_if.op1   = 32'd1000;
    u_if.op2   = 32'd3;
    u_if.rd    = 5'd9;
    @(posedge clk);
    #1 u_if.m_unit_start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    u_if.m_unit_kill  = 1'b1;
    u_if.m_unit_start = 1'b1;
    u_if.func3 = 3'b101;
    #1;
    n_cmp++; if (u_if.m_unit_busy !== 1'b1) begin n_bad++; $display("FAIL kill_busy_same got %b want 1", u_if.m_unit_busy); end
    @(posedge clk);
    #1;
    u_if.m_unit_kill  = 1'b0;
    u_if.m_unit_start = 1'b0;
    @(negedge clk);
    n_cmp++; if (u_if.m_unit_busy !== 1'b0) begin n_bad++; $display("FAIL kill_busy_next got %b want 0", u_if.m_unit_busy); end
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (u_if.m_unit_ready) seen++;
      @(negedge clk);
    end
    n_cmp++; if (seen != 0) begin n_bad++; $display("FAIL kill_no_ready got %0d pulses want 0", seen); end
  endtask

  task automatic test_reset_mid();
    int seen;
    @(negedge clk);
    u_if.m_unit_start = 1'b1;
    u_if.func3 = 3'b101;
    u_if.op1   = 32'd100;
    u_if.op2   = 32'd7;
    u_if.rd    = 5'd3;
    @(posedge clk);
    #1 u_if.m_unit_start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++; if (u_if.m_unit_busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_busy got %b want 0", u_if.m_unit_busy); end
    n_cmp++; if ({u_if.m_unit_ready, u_if.m_unit_wr, u_if.m_unit_dest, u_if.m_unit_result} !== 39'd0) begin
      n_bad++; $display("FAIL rstmid_outputs got ready=%b wr=%b dest=%0d result=%h want all 0",
                        u_if.m_unit_ready, u_if.m_unit_wr, u_if.m_unit_dest, u_if.m_unit_result);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (u_if.m_unit_ready) seen++;
    end
    n_cmp++; if (seen != 0) begin n_bad++; $display("FAIL rstmid_no_ready got %0d pulses want 0", seen); end
  endtask

  task automatic test_back_to_back();
    int lat, bcnt; logic [31:0] res; logic wr, bsy0; logic [4:0] dst;
    exec(1'b0, 3'b000, 32'd7, 32'hFFFF_FFFD, 5'd5, lat, res, wr, dst, bsy0, bcnt);
    n_cmp++; if (dst !== 5'd5) begin n_bad++; $display("FAIL b2b_first_dest got %0d want 5", dst); end
    n_cmp++; if (res !== 32'hFFFF_FFEB) begin n_bad++; $display("FAIL b2b_first_result got %h want ffffffeb", res); end
    exec(1'b1, 3'b101, 32'd100, 32'd7, 5'd9, lat, res, wr, dst, bsy0, bcnt);
    n_cmp++; if (bsy0 !== 1'b1) begin n_bad++; $display("FAIL b2b_accept_busy got %b want 1", bsy0); end
    n_cmp++; if (lat != LAT_DIV) begin n_bad++; $display("FAIL b2b_latency got %0d want %0d", lat, LAT_DIV); end
    n_cmp++; if (dst !== 5'd9) begin n_bad++; $display("FAIL b2b_second_dest got %0d want 9", dst); end
    n_cmp++; if (res !== 32'd14) begin n_bad++; $display("FAIL b2b_second_result got %h want 0000000e", res); end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_mulh();
    test_div();
    test_special();
    test_kill();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
